// File: rtl/xmem_ag.sv
// Versat memory functional unit: true-dual-port RAM driven by two 2-level address
// generators, with host access on port A that takes priority over generator A.

module xmem_ag_gen #(
  parameter int ADDR_W   = 10,
  parameter int PERIOD_W = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                stall,
  input  logic [ADDR_W-1:0]   iter,
  input  logic [PERIOD_W-1:0] per,
  input  logic [PERIOD_W-1:0] duty,
  input  logic [ADDR_W-1:0]   start,
  input  logic [ADDR_W-1:0]   shift,
  input  logic [ADDR_W-1:0]   incr,
  input  logic [ADDR_W-1:0]   mask,
  input  logic [PERIOD_W-1:0] delay,
  input  logic                reverse,
  output logic [ADDR_W-1:0]   genAddr,
  output logic                en,
  output logic                done
);

  typedef enum logic [1:0] {IDLE = 2'd0, DELAY = 2'd1, RUN = 2'd2, DONE = 2'd3} state_t;

  localparam logic [PERIOD_W-1:0] P_ZERO = {PERIOD_W{1'b0}};
  localparam logic [PERIOD_W-1:0] P_ONE  = {{(PERIOD_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0]   A_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0]   A_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t              state_r;
  logic [PERIOD_W-1:0] j_r;
  logic [PERIOD_W-1:0] delayCnt_r;
  logic [ADDR_W-1:0]   i_r;
  logic [ADDR_W-1:0]   offset_r;
  logic                done_r;
  logic                zeroLen_s;
  logic                lastJ_s;
  logic                lastI_s;
  logic [ADDR_W-1:0]   linAddr_s;

  function automatic logic [ADDR_W-1:0] bitRev(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] r;
    for (int k = 0; k < ADDR_W; k++) begin
      r[k] = a[ADDR_W-1-k];
    end
    return r;
  endfunction

  // Address, enable and end-of-loop decode from the counter state
  always_comb begin
    zeroLen_s = (iter == A_ZERO) || (per == P_ZERO);
    lastJ_s   = (j_r == (per - P_ONE));
    lastI_s   = (i_r == (iter - A_ONE));
    en        = (state_r == RUN) && !zeroLen_s && (j_r < duty) && !stall;
    linAddr_s = start + (offset_r & mask);
    if (reverse) begin
      genAddr = bitRev(linAddr_s);
    end else begin
      genAddr = linAddr_s;
    end
  end

  // Sequencer: start delay, nested period/iteration loops, completion flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      j_r        <= P_ZERO;
      delayCnt_r <= P_ZERO;
      i_r        <= A_ZERO;
      offset_r   <= A_ZERO;
      done_r     <= 1'b1;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          if (run) begin
            j_r        <= P_ZERO;
            delayCnt_r <= P_ZERO;
            i_r        <= A_ZERO;
            offset_r   <= A_ZERO;
            done_r     <= 1'b0;
            state_r    <= (delay == P_ZERO) ? RUN : DELAY;
          end
        end
        DELAY: begin
          if (delayCnt_r == (delay - P_ONE)) begin
            state_r <= RUN;
          end else begin
            delayCnt_r <= delayCnt_r + P_ONE;
          end
        end
        RUN: begin
          if (zeroLen_s) begin
            state_r <= DONE;
            done_r  <= 1'b1;
          end else if (!stall) begin
            if (lastJ_s) begin
              j_r      <= P_ZERO;
              i_r      <= i_r + A_ONE;
              offset_r <= offset_r + shift;
              if (lastI_s) begin
                state_r <= DONE;
                done_r  <= 1'b1;
              end
            end else begin
              j_r      <= j_r + P_ONE;
              offset_r <= offset_r + incr;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          done_r  <= 1'b1;
        end
      endcase
    end
  end

  assign done = done_r;

endmodule

module xmem_ag #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 10,
  parameter int PERIOD_W = 5,
  parameter int N_IN     = 4,
  localparam int SEL_W   = (N_IN > 1) ? $clog2(N_IN) : 1,
  localparam int CONF_W  = 5*ADDR_W + 3*PERIOD_W + SEL_W + 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   run,
  output logic                   doneA,
  output logic                   doneB,
  input  logic                   valid,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      rdata,
  input  logic [N_IN*DATA_W-1:0] flow_in,
  output logic [2*DATA_W-1:0]    flow_out,
  input  logic [2*CONF_W-1:0]    config_bits
);

  localparam int WR_B    = 0;
  localparam int EXT_B   = 1;
  localparam int REV_B   = 2;
  localparam int DLY_L   = 3;
  localparam int MASK_L  = DLY_L + PERIOD_W;
  localparam int INCR_L  = MASK_L + ADDR_W;
  localparam int SHIFT_L = INCR_L + ADDR_W;
  localparam int START_L = SHIFT_L + ADDR_W;
  localparam int SEL_L   = START_L + ADDR_W;
  localparam int DUTY_L  = SEL_L + SEL_W;
  localparam int PER_L   = DUTY_L + PERIOD_W;
  localparam int ITER_L  = PER_L + PERIOD_W;

  logic [CONF_W-1:0]   confA_s;
  logic [CONF_W-1:0]   confB_s;
  logic [SEL_W-1:0]    selA_s;
  logic [SEL_W-1:0]    selB_s;
  logic [DATA_W-1:0]   inA_s;
  logic [DATA_W-1:0]   inB_s;
  logic [ADDR_W-1:0]   genAddrA_s;
  logic [ADDR_W-1:0]   genAddrB_s;
  logic                genEnA_s;
  logic                genEnB_s;
  logic [ADDR_W-1:0]   addrA_s;
  logic [ADDR_W-1:0]   addrB_s;
  logic [DATA_W-1:0]   dataA_s;
  logic [DATA_W-1:0]   dataB_s;
  logic                wrA_s;
  logic                wrB_s;
  logic                enPortA_s;
  logic                enPortB_s;
  logic [DATA_W-1:0]   qA_r;
  logic [DATA_W-1:0]   qB_r;
  logic [2*DATA_W-1:0] flowOut_r;
  logic [DATA_W-1:0]   mem_r [0:(1<<ADDR_W)-1];

  assign confA_s = config_bits[2*CONF_W-1:CONF_W];
  assign confB_s = config_bits[CONF_W-1:0];
  assign selA_s  = confA_s[SEL_L +: SEL_W];
  assign selB_s  = confB_s[SEL_L +: SEL_W];

  xmem_ag_gen #(.ADDR_W(ADDR_W), .PERIOD_W(PERIOD_W)) genA (
    .clk(clk), .rst_n(rst_n), .run(run), .stall(valid),
    .iter(confA_s[ITER_L +: ADDR_W]), .per(confA_s[PER_L +: PERIOD_W]),
    .duty(confA_s[DUTY_L +: PERIOD_W]), .start(confA_s[START_L +: ADDR_W]),
    .shift(confA_s[SHIFT_L +: ADDR_W]), .incr(confA_s[INCR_L +: ADDR_W]),
    .mask(confA_s[MASK_L +: ADDR_W]), .delay(confA_s[DLY_L +: PERIOD_W]),
    .reverse(confA_s[REV_B]), .genAddr(genAddrA_s), .en(genEnA_s), .done(doneA)
  );

  xmem_ag_gen #(.ADDR_W(ADDR_W), .PERIOD_W(PERIOD_W)) genB (
    .clk(clk), .rst_n(rst_n), .run(run), .stall(1'b0),
    .iter(confB_s[ITER_L +: ADDR_W]), .per(confB_s[PER_L +: PERIOD_W]),
    .duty(confB_s[DUTY_L +: PERIOD_W]), .start(confB_s[START_L +: ADDR_W]),
    .shift(confB_s[SHIFT_L +: ADDR_W]), .incr(confB_s[INCR_L +: ADDR_W]),
    .mask(confB_s[MASK_L +: ADDR_W]), .delay(confB_s[DLY_L +: PERIOD_W]),
    .reverse(confB_s[REV_B]), .genAddr(genAddrB_s), .en(genEnB_s), .done(doneB)
  );

  // Channel select; out-of-range selectors match no channel and yield zero
  always_comb begin
    inA_s = {DATA_W{1'b0}};
    inB_s = {DATA_W{1'b0}};
    for (int c = 0; c < N_IN; c++) begin
      inA_s = (selA_s == SEL_W'(c)) ? flow_in[c*DATA_W +: DATA_W] : inA_s;
      inB_s = (selB_s == SEL_W'(c)) ? flow_in[c*DATA_W +: DATA_W] : inB_s;
    end
  end

  // Port steering: host owns port A whenever valid is high
  always_comb begin
    if (valid) begin
      addrA_s   = addr;
      dataA_s   = rdata;
      wrA_s     = we;
      enPortA_s = 1'b1;
    end else begin
      if (confB_s[EXT_B]) begin
        addrA_s = inB_s[ADDR_W-1:0];
      end else begin
        addrA_s = genAddrA_s;
      end
      dataA_s   = inA_s;
      wrA_s     = genEnA_s & confA_s[WR_B] & ~confA_s[EXT_B];
      enPortA_s = genEnA_s;
    end
    if (confA_s[EXT_B]) begin
      addrB_s = inA_s[ADDR_W-1:0];
    end else begin
      addrB_s = genAddrB_s;
    end
    dataB_s   = inB_s;
    wrB_s     = genEnB_s & confB_s[WR_B] & ~confB_s[EXT_B];
    enPortB_s = genEnB_s;
  end

  // RAM writes; port A is written last so it wins a same-address collision
  always_ff @(posedge clk) begin
    if (wrB_s) mem_r[addrB_s] <= dataB_s;
    if (wrA_s) mem_r[addrA_s] <= dataA_s;
  end

  // Read-first RAM outputs and the output pipeline register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      qA_r      <= {DATA_W{1'b0}};
      qB_r      <= {DATA_W{1'b0}};
      flowOut_r <= {(2*DATA_W){1'b0}};
    end else begin
      if (enPortA_s) qA_r <= mem_r[addrA_s];
      if (enPortB_s) qB_r <= mem_r[addrB_s];
      flowOut_r <= {qA_r, qB_r};
    end
  end

  assign flow_out = flowOut_r;

endmodule

// File: tb/tb_xmem_ag.sv
// Directed bench for xmem_ag: table of generator-A configurations read back through
// flow_out, plus hand-written stall, delay, collision and reset sequences.

module tb_xmem_ag;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 10;
  localparam int PERIOD_W = 5;
  localparam int N_IN     = 4;
  localparam int SEL_W    = 2;
  localparam int CONF_W   = 5*ADDR_W + 3*PERIOD_W + SEL_W + 3;
  localparam int NV       = 7;

  typedef struct packed {
    logic [9:0] iter;
    logic [4:0] per;
    logic [4:0] duty;
    logic [4:0] delay;
    logic [9:0] start;
    logic [9:0] shift;
    logic [9:0] incr;
    logic [9:0] mask;
    logic       rev;
    logic [7:0] runLen;
  } vec_t;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   run = 1'b0;
  logic                   valid = 1'b0;
  logic                   we = 1'b0;
  logic [ADDR_W-1:0]      addr = '0;
  logic [DATA_W-1:0]      rdata = '0;
  logic [N_IN*DATA_W-1:0] flowIn;
  logic [2*DATA_W-1:0]    flowOut;
  logic [2*CONF_W-1:0]    configBits = '0;
  logic                   doneA;
  logic                   doneB;

  int   errors = 0;
  int   checks = 0;
  vec_t vecs[NV];
  int   expAddr[NV][12];
  int   expStallA[13] = '{0, 0, 0, 10, 11, 12, 1010, 1010, 13, 14, 15, 16, 17};

  always #5 clk = ~clk;

  xmem_ag dut (
    .clk(clk), .rst_n(rst_n), .run(run), .doneA(doneA), .doneB(doneB),
    .valid(valid), .we(we), .addr(addr), .rdata(rdata),
    .flow_in(flowIn), .flow_out(flowOut), .config_bits(configBits)
  );

  task automatic check(input string name, input logic [2*DATA_W-1:0] act, input logic [2*DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CONF_W-1:0] mkConf(input int iter, input int per, input int duty,
      input int sel, input int start, input int shift, input int incr, input int mask,
      input int delay, input int rev, input int ext, input int wr);
    return {ADDR_W'(iter), PERIOD_W'(per), PERIOD_W'(duty), SEL_W'(sel), ADDR_W'(start),
            ADDR_W'(shift), ADDR_W'(incr), ADDR_W'(mask), PERIOD_W'(delay),
            1'(rev), 1'(ext), 1'(wr)};
  endfunction

  task automatic hostWrite(input int a, input int d);
    @(negedge clk);
    valid = 1'b1; we = 1'b1; addr = ADDR_W'(a); rdata = DATA_W'(d);
    @(negedge clk);
    valid = 1'b0; we = 1'b0;
  endtask

  task automatic hostRead(input int a, input int exp, input string name);
    @(negedge clk);
    valid = 1'b1; we = 1'b0; addr = ADDR_W'(a);
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    check(name, 64'(flowOut[2*DATA_W-1:DATA_W]), 64'(exp));
  endtask

  task automatic runVec(input int v);
    int dly;
    int rl;
    int k;
    int lastExp;
    dly = int'(vecs[v].delay);
    rl  = int'(vecs[v].runLen);
    configBits = {mkConf(vecs[v].iter, vecs[v].per, vecs[v].duty, 0, vecs[v].start,
                         vecs[v].shift, vecs[v].incr, vecs[v].mask, vecs[v].delay,
                         vecs[v].rev, 0, 0), {CONF_W{1'b0}}};
    hostRead(1023, 1033, $sformatf("vec%0d baseline", v));
    lastExp = 1033;
    @(negedge clk);
    run = 1'b1;
    for (int n = 1; n <= 2 + dly + rl; n++) begin
      @(negedge clk);
      run = 1'b0;
      if (n <= 1 + dly + rl)
        check($sformatf("vec%0d doneA c%0d", v, n), 64'(doneA), 64'(n == 1 + dly + rl));
      k = n - 3 - dly;
      if (k >= 0) begin
        if (expAddr[v][k] >= 0) lastExp = expAddr[v][k] + 10;
        check($sformatf("vec%0d outA k%0d", v, k), 64'(flowOut[2*DATA_W-1:DATA_W]), 64'(lastExp));
      end
    end
  endtask

  initial begin
    // iter, per, duty, delay, start, shift, incr, mask, rev, runLen
    vecs[0] = '{10'd1, 5'd8, 5'd8, 5'd0, 10'd0,    10'd0,  10'd1, 10'h3FF, 1'b0, 8'd8};
    vecs[1] = '{10'd3, 5'd4, 5'd2, 5'd0, 10'd4,    10'd5,  10'd1, 10'h3FF, 1'b0, 8'd12};
    vecs[2] = '{10'd1, 5'd8, 5'd8, 5'd0, 10'd0,    10'd0,  10'd1, 10'h003, 1'b0, 8'd8};
    vecs[3] = '{10'd1, 5'd3, 5'd3, 5'd0, 10'd1,    10'd0,  10'd1, 10'h3FF, 1'b1, 8'd3};
    vecs[4] = '{10'd2, 5'd2, 5'd1, 5'd3, 10'd100,  10'd10, 10'd2, 10'h3FF, 1'b0, 8'd4};
    vecs[5] = '{10'd1, 5'd4, 5'd4, 5'd0, 10'd1020, 10'd0,  10'd3, 10'h3FF, 1'b0, 8'd4};
    vecs[6] = '{10'd5, 5'd0, 5'd3, 5'd0, 10'd9,    10'd0,  10'd1, 10'h3FF, 1'b0, 8'd1};
    // Expected port-A address per RUN cycle; -1 = not enabled
    expAddr[0] = '{0, 1, 2, 3, 4, 5, 6, 7, 0, 0, 0, 0};
    expAddr[1] = '{4, 5, -1, -1, 12, 13, -1, -1, 20, 21, -1, -1};
    expAddr[2] = '{0, 1, 2, 3, 0, 1, 2, 3, 0, 0, 0, 0};
    expAddr[3] = '{512, 256, 768, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    expAddr[4] = '{100, -1, 112, -1, 0, 0, 0, 0, 0, 0, 0, 0};
    expAddr[5] = '{1020, 1023, 2, 5, 0, 0, 0, 0, 0, 0, 0, 0};
    expAddr[6] = '{-1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    flowIn = {32'h0, 32'h0, 32'h0000_00BB, 32'h1234_5678};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset doneA", 64'(doneA), 64'd1);
    check("reset doneB", 64'(doneB), 64'd1);
    check("reset flow_out", flowOut, 64'd0);
    rst_n = 1'b1;

    // Memory image: word a holds a+10 (addresses 0..7 hold 10..17)
    for (int a = 0; a < 1024; a++) hostWrite(a, a + 10);

    for (int v = 0; v < NV; v++) runVec(v);

    // Host stall on port A at offset 3 for two cycles; port B unaffected
    configBits = {mkConf(1, 8, 8, 0, 0, 0, 1, 1023, 0, 0, 0, 0),
                  mkConf(1, 4, 4, 0, 50, 0, 1, 1023, 0, 0, 0, 0)};
    hostRead(1023, 1033, "stall baseline");
    @(negedge clk);
    run = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      @(negedge clk);
      run = 1'b0;
      if (n >= 3) check($sformatf("stall outA c%0d", n), 64'(flowOut[2*DATA_W-1:DATA_W]), 64'(expStallA[n]));
      if (n >= 3 && n <= 6) check($sformatf("stall outB c%0d", n), 64'(flowOut[DATA_W-1:0]), 64'(57 + n));
      if (n == 10 || n == 11) check($sformatf("stall doneA c%0d", n), 64'(doneA), 64'(n == 11));
      if (n == 4 || n == 5) check($sformatf("stall doneB c%0d", n), 64'(doneB), 64'(n == 5));
      if (n == 4) begin
        valid = 1'b1; we = 1'b0; addr = 10'd1000;
      end else if (n == 6) begin
        valid = 1'b0;
      end
    end

    // Zero-length run with delay 4; extra run pulses in DELAY and RUN are ignored
    configBits = {mkConf(0, 4, 4, 0, 20, 0, 1, 1023, 4, 0, 0, 1), {CONF_W{1'b0}}};
    @(negedge clk);
    run = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(negedge clk);
      run = (n == 3 || n == 5);
      check($sformatf("zero doneA c%0d", n), 64'(doneA), 64'(n >= 6));
    end
    run = 1'b0;
    hostRead(20, 30, "zero no write");

    // Same-address write from host (port A) and generator B: A's data kept
    configBits = {mkConf(0, 0, 0, 0, 0, 0, 0, 1023, 0, 0, 0, 0),
                  mkConf(1, 1, 1, 1, 7, 0, 0, 1023, 0, 0, 0, 1)};
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0; valid = 1'b1; we = 1'b1; addr = 10'd7; rdata = 32'h0000_00AA;
    @(negedge clk);
    valid = 1'b0; we = 1'b0;
    check("collide doneB", 64'(doneB), 64'd1);
    hostRead(7, 32'hAA, "collide addr7");

    // Generator B write alone
    configBits = {mkConf(0, 0, 0, 0, 0, 0, 0, 1023, 0, 0, 0, 0),
                  mkConf(1, 1, 1, 1, 8, 0, 0, 1023, 0, 0, 0, 1)};
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (2) @(negedge clk);
    hostRead(8, 32'hBB, "portB write addr8");

    // Asynchronous reset in the middle of a long run
    configBits = {mkConf(100, 8, 8, 0, 0, 0, 1, 1023, 0, 0, 0, 0),
                  mkConf(100, 8, 8, 0, 50, 0, 1, 1023, 0, 0, 0, 0)};
    @(negedge clk);
    run = 1'b1;
    @(negedge clk);
    run = 1'b0;
    repeat (5) @(negedge clk);
    check("midrun doneA", 64'(doneA), 64'd0);
    rst_n = 1'b0;
    #1;
    check("async rst doneA", 64'(doneA), 64'd1);
    check("async rst doneB", 64'(doneB), 64'd1);
    check("async rst flow_out", flowOut, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
